// File: rtl/video_cmd_queue_if.sv
// CPU-side command bus for video_cmd_queue: one command per cycle when cmd_valid && cmd_ready.
interface video_cmd_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [1:0]  cmd_param;
   logic [10:0] cmd_index;
   logic [10:0] cmd_count;
   logic [15:0] cmd_val;

   modport master (
      output cmd_valid, cmd_op, cmd_param, cmd_index, cmd_count, cmd_val,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_param, cmd_index, cmd_count, cmd_val,
      output cmd_ready
   );
endinterface

// File: rtl/video_cmd_queue.sv
// Command FIFO plus expansion engine: single writes and fills become one video-table write per cycle.
// First write lands two edges after the push; cmd_ready is !full with no push-through on a full FIFO.
module video_cmd_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   video_cmd_if.slave  cmd,
   output logic        wen,
   output logic [1:0]  w_param,
   output logic [10:0] w_index,
   output logic [15:0] w_val,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [1:0]  op;
      logic [1:0]  param;
      logic [10:0] index;
      logic [10:0] count;
      logic [15:0] val;
   } cmd_t;

   typedef enum logic {IDLE, RUN} state_t;

   cmd_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q;
   logic          full, empty, push, pop;
   cmd_t          in_cmd, head;

   state_t        state_q, state_d;
   logic [1:0]    param_q, param_d;
   logic [10:0]   index_q, index_d;
   logic [15:0]   val_q, val_d;
   logic          incr_q, incr_d;
   logic [10:0]   rem_q, rem_d;
   logic          wen_q, wen_d;
   logic [1:0]    w_param_q, w_param_d;
   logic [10:0]   w_index_q, w_index_d;
   logic [15:0]   w_val_q, w_val_d;
   logic [10:0]   ld_rem;

   // Table sizes: paldef 16, tiledef 256, palmap/tilemap 1200.
   function automatic logic [10:0] reduce_index(input logic [1:0] p, input logic [10:0] idx);
      case (p)
         2'd0:    reduce_index = {7'd0, idx[3:0]};
         2'd1:    reduce_index = {3'd0, idx[7:0]};
         default: reduce_index = (idx >= 11'd1200) ? idx - 11'd1200 : idx;
      endcase
   endfunction

   function automatic logic [10:0] next_index(input logic [1:0] p, input logic [10:0] idx);
      case (p)
         2'd0:    next_index = {7'd0, idx[3:0] + 4'd1};
         2'd1:    next_index = {3'd0, idx[7:0] + 8'd1};
         default: next_index = (idx == 11'd1199) ? 11'd0 : idx + 11'd1;
      endcase
   endfunction

   assign full          = (cnt_q == FULL_CNT);
   assign empty         = (cnt_q == '0);
   assign cmd.cmd_ready = !full;
   assign push          = cmd.cmd_valid && !full;
   assign head          = mem_q[rd_ptr_q];

   assign in_cmd.op    = cmd.cmd_op;
   assign in_cmd.param = cmd.cmd_param;
   assign in_cmd.index = cmd.cmd_index;
   assign in_cmd.count = cmd.cmd_count;
   assign in_cmd.val   = cmd.cmd_val;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= in_cmd;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (push && !pop) begin
            cnt_q <= cnt_q + (AW+1)'(1);
         end else if (pop && !push) begin
            cnt_q <= cnt_q - (AW+1)'(1);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      param_d   = param_q;
      index_d   = index_q;
      val_d     = val_q;
      incr_d    = incr_q;
      rem_d     = rem_q;
      wen_d     = 1'b0;
      w_param_d = w_param_q;
      w_index_d = w_index_q;
      w_val_d   = w_val_q;
      pop       = 1'b0;
      ld_rem    = (head.op == 2'd1 || head.op == 2'd2) ? head.count : 11'd1;

      case (state_q)
         IDLE: begin
            pop = !empty;
         end
         RUN: begin
            wen_d     = 1'b1;
            w_param_d = param_q;
            w_index_d = index_q;
            w_val_d   = val_q;
            rem_d     = rem_q - 11'd1;
            index_d   = next_index(param_q, index_q);
            if (incr_q) begin
               val_d = val_q + 16'd1;
            end
            // Chain the next command on the last write so there is no bubble.
            if (rem_q == 11'd1) begin
               pop = !empty;
               if (empty) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A zero-count fill is consumed here and leaves the engine idle for a cycle.
      if (pop) begin
         param_d = head.param;
         index_d = reduce_index(head.param, head.index);
         val_d   = head.val;
         incr_d  = (head.op == 2'd2);
         rem_d   = ld_rem;
         state_d = (ld_rem != 11'd0) ? RUN : IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         param_q   <= '0;
         index_q   <= '0;
         val_q     <= '0;
         incr_q    <= 1'b0;
         rem_q     <= '0;
         wen_q     <= 1'b0;
         w_param_q <= '0;
         w_index_q <= '0;
         w_val_q   <= '0;
      end else begin
         state_q   <= state_d;
         param_q   <= param_d;
         index_q   <= index_d;
         val_q     <= val_d;
         incr_q    <= incr_d;
         rem_q     <= rem_d;
         wen_q     <= wen_d;
         w_param_q <= w_param_d;
         w_index_q <= w_index_d;
         w_val_q   <= w_val_d;
      end
   end

   assign wen     = wen_q;
   assign w_param = w_param_q;
   assign w_index = w_index_q;
   assign w_val   = w_val_q;
   assign busy    = !empty || (state_q == RUN);

endmodule
